// File: rtl/cmp_pkg.sv
// Shared types for the compare-sharing arbiter: FSM states, default operand
// width and the one-hot comparator result.
package cmp_pkg;

   localparam int W_DEFAULT = 4;

   typedef enum logic [1:0] {
      IDLE,
      CMP,
      RSP
   } state_t;

   typedef struct packed {
      logic lt;
      logic eq;
      logic gt;
   } cmp_result_t;

endpackage

// File: rtl/mag_compare4.sv
// Purely combinational unsigned magnitude comparator; the single datapath
// resource that the arbiter time-shares among requesters.
module mag_compare4
   import cmp_pkg::*;
#(
   parameter int W = W_DEFAULT
) (
   input  logic [W-1:0] op_a,
   input  logic [W-1:0] op_b,
   output cmp_result_t  res
);

   always_comb begin
      res.lt = (op_a < op_b);
      res.eq = (op_a == op_b);
      res.gt = (op_a > op_b);
   end

endmodule

// File: rtl/cmp_share_arbiter.sv
// Round-robin arbiter that grants one requester at a time, runs its operands
// through the shared comparator and returns a tagged lt/eq/gt response.
module cmp_share_arbiter
   import cmp_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int W    = W_DEFAULT,
   localparam int IDW = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ*W-1:0] req_a,
   input  logic [NREQ*W-1:0] req_b,
   output logic [NREQ-1:0]   req_ready,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [IDW-1:0]    rsp_id,
   output logic              rsp_lt,
   output logic              rsp_eq,
   output logic              rsp_gt,
   output logic              busy
);

   state_t         state;
   logic [IDW-1:0] last_grant;
   logic [IDW-1:0] winner;
   logic           accept;
   logic [W-1:0]   op_a;
   logic [W-1:0]   op_b;
   cmp_result_t    cmp_res;

   // Scan from last_grant+1 upward (mod NREQ); iterating backwards lets the
   // nearest requesting index overwrite any farther one.
   function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] valid,
                                              input logic [IDW-1:0]  last);
      logic [IDW-1:0] pick;
      int             idx;
      pick = last;
      for (int i = NREQ; i >= 1; i--) begin
         idx = (int'(last) + i) % NREQ;
         if (valid[idx]) pick = IDW'(idx);
      end
      return pick;
   endfunction

   // Grant is combinational in IDLE; reset forces it low immediately.
   always_comb begin
      winner    = rr_pick(req_valid, last_grant);
      accept    = (state == IDLE) && (|req_valid) && !rst;
      req_ready = '0;
      if (accept) req_ready = NREQ'(1) << winner;
   end

   assign busy = (state != IDLE);

   mag_compare4 #(.W(W)) u_cmp (
      .op_a (op_a),
      .op_b (op_b),
      .res  (cmp_res)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= IDW'(NREQ - 1);
         op_a       <= '0;
         op_b       <= '0;
         rsp_valid  <= 1'b0;
         rsp_id     <= '0;
         rsp_lt     <= 1'b0;
         rsp_eq     <= 1'b0;
         rsp_gt     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  op_a       <= req_a[int'(winner)*W +: W];
                  op_b       <= req_b[int'(winner)*W +: W];
                  rsp_id     <= winner;
                  last_grant <= winner;
                  state      <= CMP;
               end
            end
            CMP: begin
               rsp_lt    <= cmp_res.lt;
               rsp_eq    <= cmp_res.eq;
               rsp_gt    <= cmp_res.gt;
               rsp_valid <= 1'b1;
               state     <= RSP;
            end
            RSP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Directed self-checking bench for cmp_share_arbiter (NREQ=4, W=4).
module tb_cmp_share_arbiter;

   localparam int NREQ = 4;
   localparam int W    = 4;

   logic              clk;
   logic              rst;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ*W-1:0] req_a;
   logic [NREQ*W-1:0] req_b;
   logic [NREQ-1:0]   req_ready;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [1:0]        rsp_id;
   logic              rsp_lt;
   logic              rsp_eq;
   logic              rsp_gt;
   logic              busy;

   int checks = 0;
   int errors = 0;

   cmp_share_arbiter #(.NREQ(NREQ), .W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_lt    (rsp_lt),
      .rsp_eq    (rsp_eq),
      .rsp_gt    (rsp_gt),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic rdy);
      req_valid = valid;
      rsp_ready = rdy;
   endtask

   task automatic setOps(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
      req_a[idx*W +: W] = a;
      req_b[idx*W +: W] = b;
   endtask

   // Called in the low phase of an IDLE cycle with inputs already driven and
   // rsp_ready high; walks accept -> CMP -> RSP -> back to IDLE.
   task automatic doCompare(input string tag, input logic [NREQ-1:0] expReady,
                            input logic [1:0] expId, input logic [2:0] expRes);
      #1;
      checkOutput({tag, " grant"}, 32'(req_ready), 32'(expReady));
      checkOutput({tag, " idle busy"}, 32'(busy), 32'd0);
      @(negedge clk);
      checkOutput({tag, " cmp busy"}, 32'(busy), 32'd1);
      checkOutput({tag, " cmp ready"}, 32'(req_ready), 32'd0);
      checkOutput({tag, " cmp valid"}, 32'(rsp_valid), 32'd0);
      @(negedge clk);
      checkOutput({tag, " rsp valid"}, 32'(rsp_valid), 32'd1);
      checkOutput({tag, " rsp id"}, 32'(rsp_id), 32'(expId));
      checkOutput({tag, " rsp result"}, 32'({rsp_lt, rsp_eq, rsp_gt}), 32'(expRes));
      @(negedge clk);
      checkOutput({tag, " back idle"}, 32'({busy, rsp_valid}), 32'd0);
   endtask

   logic [NREQ-1:0] rrReady [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
   logic [1:0]      rrId    [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
   logic [2:0]      rrRes   [5] = '{3'b100, 3'b010, 3'b001, 3'b100, 3'b100};

   initial begin
      rst   = 1'b1;
      req_a = '0;
      req_b = '0;
      applyStimulus(4'b1111, 1'b1);
      #3;
      checkOutput("reset rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("reset busy", 32'(busy), 32'd0);
      checkOutput("reset req_ready", 32'(req_ready), 32'd0);
      checkOutput("reset rsp_id", 32'(rsp_id), 32'd0);
      checkOutput("reset result", 32'({rsp_lt, rsp_eq, rsp_gt}), 32'd0);

      @(negedge clk);
      rst = 1'b0;
      applyStimulus(4'b0001, 1'b1);
      setOps(0, 4'd9, 4'd3);
      doCompare("9vs3", 4'b0001, 2'd0, 3'b001);
      setOps(0, 4'd5, 4'd5);
      doCompare("5vs5", 4'b0001, 2'd0, 3'b010);
      setOps(0, 4'd2, 4'd14);
      doCompare("2vs14", 4'b0001, 2'd0, 3'b100);
      setOps(0, 4'd15, 4'd0);
      doCompare("15vs0", 4'b0001, 2'd0, 3'b001);
      setOps(0, 4'd0, 4'd15);
      doCompare("0vs15", 4'b0001, 2'd0, 3'b100);

      // Fresh reset so the rotation starts at requester 0.
      rst = 1'b1;
      #1;
      rst = 1'b0;
      setOps(0, 4'd1, 4'd2);
      setOps(1, 4'd7, 4'd7);
      setOps(2, 4'd12, 4'd4);
      setOps(3, 4'd3, 4'd8);
      applyStimulus(4'b1111, 1'b1);
      for (int k = 0; k < 5; k++) begin
         doCompare($sformatf("rr%0d", k), rrReady[k], rrId[k], rrRes[k]);
      end

      // Back-pressure: last_grant is 0, only 1 and 2 requesting -> 1? no: 2 only first.
      applyStimulus(4'b0100, 1'b0);
      setOps(2, 4'd6, 4'd9);
      #1;
      checkOutput("bp grant", 32'(req_ready), 32'b0100);
      @(negedge clk);
      @(negedge clk);
      applyStimulus(4'b0110, 1'b0);
      setOps(1, 4'd11, 4'd11);
      for (int k = 0; k < 10; k++) begin
         checkOutput($sformatf("bp hold%0d", k),
                     32'({rsp_valid, busy, req_ready, rsp_id, rsp_lt, rsp_eq, rsp_gt}),
                     32'({1'b1, 1'b1, 4'b0000, 2'd2, 3'b100}));
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      checkOutput("bp released", 32'(rsp_valid), 32'd0);
      doCompare("bp next", 4'b0010, 2'd1, 3'b010);

      // Skip/rotate with last_grant = 1 and only 1 and 3 requesting.
      applyStimulus(4'b1010, 1'b1);
      setOps(3, 4'd14, 4'd13);
      setOps(1, 4'd4, 4'd4);
      doCompare("skip3", 4'b1000, 2'd3, 3'b001);
      doCompare("skip1", 4'b0010, 2'd1, 3'b010);

      // Async reset while in CMP.
      applyStimulus(4'b0100, 1'b1);
      setOps(2, 4'd1, 4'd0);
      #1;
      checkOutput("ar grant", 32'(req_ready), 32'b0100);
      @(negedge clk);
      checkOutput("ar in cmp", 32'(busy), 32'd1);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("ar outputs", 32'({rsp_valid, busy, req_ready, rsp_id}), 32'd0);
      #1;
      rst = 1'b0;
      applyStimulus(4'b1111, 1'b1);
      setOps(0, 4'd8, 4'd8);
      doCompare("ar first", 4'b0001, 2'd0, 3'b010);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      errors++;
      $display("[TB] FAIL timeout: simulation did not complete");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "[TB] timeout");
   end

endmodule
